// File: rtl/acs_scheduler_if.sv
// Symbol, ACS and decision handshake bundle for acs_scheduler.
// slave = scheduler side, master = environment (symbol source, ACS unit, decision sink).
interface acs_scheduler_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] sym_bm;

    logic       acs_path_0_valid;
    logic       acs_path_1_valid;
    logic [1:0] acs_path_0_bmc;
    logic [1:0] acs_path_1_bmc;
    logic [7:0] acs_path_0_pmc;
    logic [7:0] acs_path_1_pmc;
    logic       acs_selection;
    logic       acs_valid_o;
    logic [7:0] acs_path_cost;

    logic       dec_valid;
    logic       dec_ready;
    logic [7:0] dec_bits;
    logic [7:0] dec_states_valid;
    logic [2:0] best_state;
    logic [7:0] best_metric;

    modport slave (
        input  sym_valid, sym_bm, acs_selection, acs_valid_o, acs_path_cost, dec_ready,
        output sym_ready, acs_path_0_valid, acs_path_1_valid, acs_path_0_bmc, acs_path_1_bmc,
               acs_path_0_pmc, acs_path_1_pmc, dec_valid, dec_bits, dec_states_valid,
               best_state, best_metric
    );

    modport master (
        output sym_valid, sym_bm, acs_selection, acs_valid_o, acs_path_cost, dec_ready,
        input  sym_ready, acs_path_0_valid, acs_path_1_valid, acs_path_0_bmc, acs_path_1_bmc,
               acs_path_0_pmc, acs_path_1_pmc, dec_valid, dec_bits, dec_states_valid,
               best_state, best_metric
    );
endinterface

// File: rtl/acs_scheduler.sv
// 8-state Viterbi ACS scheduler: walks one external ACS unit over all states, ping-pong metric banks.
// Decision valid 9 cycles after symbol accept; holds DONE until dec_ready, no new symbol meanwhile.
module acs_scheduler (
    input  logic          clk,
    input  logic          rst,
    acs_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [2:0] idx;
    logic       cur;
    logic       nxt;
    logic [7:0] bm_q;
    logic [7:0] metric [2][8];
    logic [7:0] valid_v [2];

    logic [7:0] run_min;
    logic [2:0] run_state;
    logic       run_found;

    logic [7:0] dec_bits_q;
    logic [7:0] dec_sv_q;
    logic [2:0] best_state_q;
    logic [7:0] best_metric_q;

    function automatic logic [1:0] exp_code(input logic [2:0] p, input logic b);
        return {b ^ p[1] ^ p[0], b ^ p[2] ^ p[0]};
    endfunction

    function automatic logic [1:0] pick_bm(input logic [7:0] bm, input logic [1:0] c);
        return bm[{c, 1'b0} +: 2];
    endfunction

    logic [2:0] p0;
    logic [2:0] p1;
    logic       in_bit;
    logic       active;

    assign nxt    = ~cur;
    assign in_bit = idx[0];
    assign p0     = {1'b0, idx[2:1]};
    assign p1     = {1'b1, idx[2:1]};
    assign active = (state == RUN) && !rst;

    assign bus.acs_path_0_valid = active & valid_v[cur][p0];
    assign bus.acs_path_1_valid = active & valid_v[cur][p1];
    assign bus.acs_path_0_bmc   = active ? pick_bm(bm_q, exp_code(p0, in_bit)) : 2'b00;
    assign bus.acs_path_1_bmc   = active ? pick_bm(bm_q, exp_code(p1, in_bit)) : 2'b00;
    assign bus.acs_path_0_pmc   = active ? metric[cur][p0] : 8'h00;
    assign bus.acs_path_1_pmc   = active ? metric[cur][p1] : 8'h00;

    assign bus.sym_ready        = (state == IDLE);
    assign bus.dec_valid        = (state == DONE);
    assign bus.dec_bits         = dec_bits_q;
    assign bus.dec_states_valid = dec_sv_q;
    assign bus.best_state       = best_state_q;
    assign bus.best_metric      = best_metric_q;

    logic [7:0] wr_cost;
    logic       wr_sel;
    logic [7:0] nv_w;
    logic [7:0] hi_w;
    logic       norm;
    logic       take;
    logic [7:0] fin_min;
    logic [2:0] fin_state;
    logic       fin_found;

    // View of the next bank including this cycle's write, used at the swap.
    always_comb begin
        wr_cost = bus.acs_valid_o ? bus.acs_path_cost : 8'h00;
        wr_sel  = bus.acs_valid_o & bus.acs_selection;
        nv_w    = valid_v[nxt];
        nv_w[idx] = bus.acs_valid_o;
        hi_w    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            hi_w[i] = metric[nxt][i][7];
        end
        hi_w[idx] = wr_cost[7];
        norm      = (|nv_w) && ((nv_w & ~hi_w) == 8'h00);
        take      = bus.acs_valid_o && (!run_found || (bus.acs_path_cost < run_min));
        fin_min   = take ? bus.acs_path_cost : run_min;
        fin_state = take ? idx : run_state;
        fin_found = run_found | bus.acs_valid_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            cur   <= 1'b0;
            bm_q  <= 8'h00;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) begin
                    metric[k][i] <= 8'h00;
                end
            end
            valid_v[0]    <= 8'h01;
            valid_v[1]    <= 8'h00;
            run_min       <= 8'h00;
            run_state     <= 3'd0;
            run_found     <= 1'b0;
            dec_bits_q    <= 8'h00;
            dec_sv_q      <= 8'h00;
            best_state_q  <= 3'd0;
            best_metric_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sym_valid) begin
                        bm_q      <= bus.sym_bm;
                        idx       <= 3'd0;
                        run_min   <= 8'h00;
                        run_state <= 3'd0;
                        run_found <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    metric[nxt][idx]  <= wr_cost;
                    valid_v[nxt][idx] <= bus.acs_valid_o;
                    dec_bits_q[idx]   <= wr_sel;
                    run_min           <= fin_min;
                    run_state         <= fin_state;
                    run_found         <= fin_found;
                    idx               <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        cur           <= nxt;
                        state         <= DONE;
                        dec_sv_q      <= nv_w;
                        best_state_q  <= fin_state;
                        best_metric_q <= {fin_min[7] & ~norm, fin_min[6:0]};
                        // Invalid entries hold 0, so clearing bit7 everywhere is safe.
                        if (norm) begin
                            for (int i = 0; i < 8; i++) begin
                                metric[nxt][i][7] <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.dec_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acs_scheduler.sv
// Directed bench for acs_scheduler with a behavioural ACS unit on the acs_* ports.
module tb_acs_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    acs_scheduler_if bus();

    acs_scheduler dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // External add-compare-select unit: ties select path 0.
    logic [7:0] cost0, cost1;
    always_comb begin
        cost0 = bus.acs_path_0_pmc + {6'd0, bus.acs_path_0_bmc};
        cost1 = bus.acs_path_1_pmc + {6'd0, bus.acs_path_1_bmc};
        bus.acs_selection = 1'b0;
        bus.acs_valid_o   = 1'b0;
        bus.acs_path_cost = 8'h00;
        if (bus.acs_path_0_valid && bus.acs_path_1_valid) begin
            bus.acs_valid_o = 1'b1;
            if (cost1 < cost0) begin
                bus.acs_selection = 1'b1;
                bus.acs_path_cost = cost1;
            end else begin
                bus.acs_path_cost = cost0;
            end
        end else if (bus.acs_path_0_valid) begin
            bus.acs_valid_o   = 1'b1;
            bus.acs_path_cost = cost0;
        end else if (bus.acs_path_1_valid) begin
            bus.acs_valid_o   = 1'b1;
            bus.acs_selection = 1'b1;
            bus.acs_path_cost = cost1;
        end
    end

    typedef struct {
        logic [7:0] bm;
        logic [7:0] dsv;
        logic [7:0] bits;
        logic [2:0] bst;
        logic [7:0] bmet;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_dec(input string tag, input vec_t v);
        chk({tag, "_dsv"},  {24'd0, bus.dec_states_valid}, {24'd0, v.dsv});
        chk({tag, "_bits"}, {24'd0, bus.dec_bits},         {24'd0, v.bits});
        chk({tag, "_bst"},  {29'd0, bus.best_state},       {29'd0, v.bst});
        chk({tag, "_bmet"}, {24'd0, bus.best_metric},      {24'd0, v.bmet});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym_bm    = 8'h00;
        bus.dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offers a symbol, returns cycles from acceptance to dec_valid (40 = never).
    task automatic send(input logic [7:0] bm, input logic rdy, output int lat);
        int n;
        n = 0;
        bus.dec_ready = rdy;
        bus.sym_bm    = bm;
        bus.sym_valid = 1'b1;
        while (!bus.sym_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.sym_valid = 1'b0;
        bus.sym_bm    = 8'h5A;
        lat = 1;
        while (!bus.dec_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic post_ready(input string tag);
        @(negedge clk);
        chk({tag, "_symrdy_back"}, {31'd0, bus.sym_ready}, 32'd1);
        chk({tag, "_decv_low"},    {31'd0, bus.dec_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   lat;
        vec_t v;
        vec_t hold;

        tbl[0] = '{8'hE4, 8'h03, 8'h00, 3'd0, 8'd0};
        tbl[1] = '{8'hE4, 8'h0F, 8'h00, 3'd0, 8'd0};
        tbl[2] = '{8'hE4, 8'hFF, 8'h00, 3'd0, 8'd0};
        tbl[3] = '{8'h1B, 8'hFF, 8'h30, 3'd1, 8'd0};
        tbl[4] = '{8'h00, 8'hFF, 8'hC0, 3'd2, 8'd0};
        tbl[5] = '{8'h00, 8'hFF, 8'h00, 3'd4, 8'd0};

        // Reset values, sampled while rst is still high.
        bus.sym_valid = 1'b0;
        bus.sym_bm    = 8'h00;
        bus.dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sym_ready", {31'd0, bus.sym_ready}, 32'd1);
        chk("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        chk("rst_dec_bits",  {24'd0, bus.dec_bits}, 32'd0);
        chk("rst_dsv",       {24'd0, bus.dec_states_valid}, 32'd0);
        chk("rst_best",      {21'd0, bus.best_state, bus.best_metric}, 32'd0);
        chk("rst_acs_zero",  {10'd0, bus.acs_path_0_valid, bus.acs_path_1_valid, bus.acs_path_0_bmc,
                              bus.acs_path_1_bmc, bus.acs_path_0_pmc, bus.acs_path_1_pmc}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: consecutive symbols from reset, dec_ready held high.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].bm, 1'b1, lat);
            chk($sformatf("row%0d_latency", i), lat, 32'd9);
            check_dec($sformatf("row%0d", i), tbl[i]);
            post_ready($sformatf("row%0d", i));
        end

        // Decision held under backpressure while another symbol is pending.
        hold = tbl[5];
        send(hold.bm, 1'b0, lat);
        chk("hold_latency", lat, 32'd9);
        bus.sym_valid = 1'b1;
        bus.sym_bm    = 8'hE4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", c),
                {2'b0, bus.dec_valid, bus.sym_ready, bus.dec_states_valid, bus.dec_bits, 1'b0, bus.best_state, bus.best_metric[3:0]},
                {2'b0, 1'b1, 1'b0, hold.dsv, hold.bits, 1'b0, hold.bst, hold.bmet[3:0]});
        end
        chk("hold_bmet", {24'd0, bus.best_metric}, {24'd0, hold.bmet});
        bus.dec_ready = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        chk("hold_release_symrdy", {31'd0, bus.sym_ready}, 32'd1);
        chk("hold_release_decv",   {31'd0, bus.dec_valid}, 32'd0);

        // Reset in the middle of RUN.
        do_reset();
        bus.dec_ready = 1'b1;
        bus.sym_bm    = 8'hE4;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        chk("run0_p_valid", {30'd0, bus.acs_path_0_valid, bus.acs_path_1_valid}, 32'd2);
        chk("run0_bmc",     {28'd0, bus.acs_path_0_bmc, bus.acs_path_1_bmc}, 32'd1);
        chk("run0_symrdy",  {31'd0, bus.sym_ready}, 32'd0);
        repeat (4) @(negedge clk);
        chk("run4_bmc0", {30'd0, bus.acs_path_0_bmc}, 32'd2);
        rst = 1'b1;
        #1;
        chk("midrun_rst_acs_zero", {10'd0, bus.acs_path_0_valid, bus.acs_path_1_valid, bus.acs_path_0_bmc,
                                    bus.acs_path_1_bmc, bus.acs_path_0_pmc, bus.acs_path_1_pmc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_symrdy", {31'd0, bus.sym_ready}, 32'd1);
        chk("midrun_rst_decv",   {31'd0, bus.dec_valid}, 32'd0);
        chk("midrun_rst_bits",   {24'd0, bus.dec_bits}, 32'd0);
        send(8'hE4, 1'b1, lat);
        chk("after_rst_latency", lat, 32'd9);
        check_dec("after_rst", tbl[0]);
        post_ready("after_rst");

        // All-ones stream: metric grows by 3 per symbol, normalised at 129.
        do_reset();
        @(negedge clk);
        for (int n = 1; n <= 43; n++) begin
            send(8'hFF, 1'b1, lat);
            if (n <= 3 || n == 10 || n >= 42) begin
                v.bm   = 8'hFF;
                v.dsv  = (n == 1) ? 8'h03 : (n == 2) ? 8'h0F : 8'hFF;
                v.bits = 8'h00;
                v.bst  = 3'd0;
                v.bmet = (n == 43) ? 8'd1 : 8'(3 * n);
                chk($sformatf("ff%0d_latency", n), lat, 32'd9);
                check_dec($sformatf("ff%0d", n), v);
            end
            @(negedge clk);
        end

        // Equal predecessor costs everywhere: path 0 chosen, lowest state wins.
        send(8'h00, 1'b1, lat);
        v = '{8'h00, 8'hFF, 8'h00, 3'd0, 8'd1};
        chk("tie_latency", lat, 32'd9);
        check_dec("tie", v);
        post_ready("tie");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acs_scheduler.md
ACS_SCHEDULER -- requirements
Module: acs_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, listed first:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
REQ-002 SHALL have these symbol-side ports:
- sym_valid  input  1  branch-metric set offered.
- sym_ready  output  1  scheduler accepts a set this cycle.
- sym_bm  input  8  four 2-bit branch metrics; sym_bm[2c+1:2c] is the metric for expected code c (0..3).
REQ-003 SHALL have these ACS-side ports, which drive one external combinational add-compare-select unit:
- acs_path_0_valid, acs_path_1_valid  output  1 each  predecessor valid flags.
- acs_path_0_bmc, acs_path_1_bmc  output  2 each  branch metrics.
- acs_path_0_pmc, acs_path_1_pmc  output  8 each  predecessor path metrics.
- acs_selection, acs_valid_o  input  1 each  ACS result flags, valid in the same cycle.
- acs_path_cost  input  8  ACS result cost, valid in the same cycle.
REQ-004 SHALL have these decision-side ports:
- dec_valid  output  1  decision word available.
- dec_ready  input  1  consumer accepts.
- dec_bits  output  8  per-state selection.
- dec_states_valid  output  8  per-state valid.
- best_state  output  3  lowest-metric valid state.
- best_metric  output  8  metric of best_state.

Function
REQ-005 SHALL implement an 8-state trellis: previous state p maps to new state ns={p[1:0],b}; predecessors of ns are p0={0,ns[2:1]} and p1={1,ns[2:1]}; input bit b=ns[0].
REQ-006 SHALL compute the expected code for transition p->ns as c={b^p[1]^p[0], b^p[2]^p[0]}, and drive acs_path_k_bmc=sym_bm[2c+1:2c] for predecessor pk.
REQ-007 SHALL hold two 8x8-bit metric banks plus an 8-bit valid vector per bank, ping-pong: read the current bank, write the next bank.
REQ-008 SHALL implement FSM states IDLE, RUN, DONE.
REQ-009 In IDLE, SHALL assert sym_ready=1; on sym_valid&&sym_ready, SHALL latch sym_bm, set idx=0, and go to RUN.
REQ-010 In RUN, SHALL present ns=idx to the ACS: acs_path_k_pmc=cur_metric[pk], acs_path_k_valid=cur_valid[pk].
REQ-011 In RUN, SHALL in the same cycle write acs_path_cost to next_metric[idx], acs_valid_o to next_valid[idx], and acs_selection to dec_bits[idx]; invalid states SHALL store metric 0 and selection 0.
REQ-012 In RUN, SHALL track the running minimum over valid states, updating only on a strictly smaller cost, so the lowest index wins ties.
REQ-013 SHALL increment idx each RUN cycle; when idx=7 completes, SHALL swap banks and go to DONE; RUN therefore lasts exactly 8 cycles.
REQ-014 On the swap, SHALL normalize: if every valid new metric has bit7=1 and at least one state is valid, SHALL clear bit7 of all valid metrics; best_metric SHALL be reported post-normalization.
REQ-015 In DONE, SHALL assert dec_valid=1 with dec_bits, dec_states_valid, best_state and best_metric held stable until dec_ready=1; on handshake, SHALL return to IDLE.
REQ-016 Latency: with dec_ready held 1, a symbol accepted at cycle T SHALL produce dec_valid at cycle T+9, and sym_ready SHALL return at T+10; throughput is one symbol per 10 cycles.
REQ-017 sym_ready SHALL be 0 in RUN and DONE; sym_bm SHALL be ignored outside IDLE.
REQ-018 Metric arithmetic is 8-bit unsigned with no saturation; overflow prevention relies solely on REQ-014.

Reset
REQ-019 On rst=1 at a clock edge, in any state including mid-RUN, SHALL go to IDLE and set sym_ready=1, dec_valid=0, dec_bits=0, dec_states_valid=0, best_state=0, best_metric=0.
REQ-020 On reset, SHALL clear all metrics to 0, set current valid=8'h01 (state 0 only), and set next valid=0.
REQ-021 While rst=1, all acs_* outputs SHALL be 0; rst SHALL take priority over any simultaneous handshake.

Verification
REQ-022 After reset, one symbol with sym_bm=8'hE4 (code c has metric c) -> dec_states_valid=8'h03, dec_bits=8'h00, best_state=0, best_metric=0; dec_valid rises exactly 9 cycles after acceptance.
REQ-023 Hold dec_ready=0 for 20 cycles in DONE -> dec_valid stays 1, all decision outputs stable, sym_ready=0, a pending sym_valid is not accepted.
REQ-024 Stream sym_bm=8'hFF with dec_ready=1 -> from symbol 3 on dec_states_valid=8'hFF; symbol 42 gives best_metric=126; symbol 43 gives best_metric=1 (129 normalized).
REQ-025 Assert rst during RUN idx=4 -> next cycle IDLE, sym_ready=1, dec_valid=0; the next symbol behaves exactly as in REQ-022.
REQ-026 Equal predecessor costs (sym_bm=8'h00 after state saturation) -> every dec_bits bit =0, best_state=0.
